fft_frame_streamer: RTL and testbench
=====================================

Name: fft_frame_streamer

Overview:
- Consumer at the far end of the parallel FFT result interface: captures packed N-point complex frames and re-serializes them into a one-sample-per-beat valid/ready stream for downstream scalar DSP blocks.
- Two-bank ping-pong buffer, so a new frame can be captured while the previous one is still streaming out.
- Frames arriving with both banks full are dropped and counted.

Parameters:
- DATA_WIDTH, 16, bits per real/imag component (signed two's complement).
- FFT_POINTS, 8, samples per frame; power of 2, >= 2.
- LOG2_FFT_POINTS, $clog2(FFT_POINTS), index width.
- DROP_CNT_WIDTH, 8, width of the saturating dropped-frame counter.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- frame_real_in  in  DATA_WIDTH*FFT_POINTS  packed real parts; sample i is at bits [(i+1)*DATA_WIDTH-1 -: DATA_WIDTH].
- frame_imag_in  in  DATA_WIDTH*FFT_POINTS  packed imag parts, same packing.
- frame_valid_in  in  1  level-held frame-valid; a frame is offered on its rising edge.
- frame_ready  out  1  registered; 1 when fewer than 2 banks are full.
- sample_real  out  DATA_WIDTH  streamed real component.
- sample_imag  out  DATA_WIDTH  streamed imag component.
- sample_index  out  LOG2_FFT_POINTS  bin index of the current sample.
- sample_last  out  1  high with index FFT_POINTS-1.
- sample_valid  out  1  output valid.
- sample_ready  in  1  downstream accept.
- busy  out  1  high when any bank is full or sample_valid=1.
- drop_count  out  DROP_CNT_WIDTH  saturating count of dropped frames.

Behaviour:
- Reset (async assert, sync release): all outputs 0 except frame_ready=1. Bank-full count=0, write bank=0, read bank=0, edge-detect register=0. Reset mid-stream discards both banks and any in-flight sample.
- Capture:
  - A capture event occurs when frame_valid_in=1 and its registered previous value is 0.
  - If full count < 2: both buses are copied into the write bank, the write bank toggles and the count increments.
  - Otherwise the frame is dropped and drop_count increments, saturating at all-ones.
  - A level held high never re-captures.
- Stream FSM:
  - IDLE: sample_valid=0. When count > 0, go to STREAM and present index 0 of the read bank on the next edge. Capture at edge N gives sample_valid=1 after edge N+1.
  - STREAM: sample_real, sample_imag, sample_index and sample_last stay stable while sample_valid && !sample_ready.
  - On accept of a non-last sample, the next index is presented on the next edge with no bubble.
  - On accept of the last sample: the bank is freed (count decrements) and the read bank toggles. If the other bank is full, its index 0 is presented the next cycle with no bubble; otherwise return to IDLE with sample_valid=0.
- Simultaneous last-accept and capture in one cycle: count is net unchanged. A capture into a bank freed the same cycle is allowed only if count was < 2 before that edge. With count=2, the frame is dropped even if a bank frees that cycle.
- Output order: natural order 0..FFT_POINTS-1. Values are passed bit-exact, with no arithmetic.
- frame_ready is computed from the post-edge count. busy uses the same post-edge state.

Optional Feature:
- FFT_STREAM_MAG_EN defined: adds output port sample_mag (DATA_WIDTH+1 bits, unsigned).
  - Value is the alpha-max-beta-min estimate max(|re|,|im|) + (min(|re|,|im|) >> 1).
  - Computed at capture-to-present time and registered alongside sample_real, with identical timing and hold behaviour.
  - |-2^(DATA_WIDTH-1)| is represented exactly in the widened path.
- Not defined: no sample_mag port and no extra logic. All other behaviour is identical.

Test Plan:
- Single frame (DATA_WIDTH=16, FFT_POINTS=8, sample i real=i*0x100, imag=-i), sample_ready=1 -> 8 consecutive beats, index 0..7, sample_last on index 7, sample 3 = (0x0300, 0xFFFD). Then busy=0 and frame_ready=1.
- Backpressure: sample_ready toggles 1,0,0,1... -> outputs held stable during stalls; no sample lost or duplicated; order 0..7.
- frame_valid_in held high for 40 cycles -> exactly one frame captured and drop_count=0.
- Three rising edges with sample_ready=0 -> two frames buffered, third dropped (drop_count=1, frame_ready=0). Releasing ready streams frame A then frame B back-to-back with no bubble between A's index 7 and B's index 0.
- rst_n pulsed low mid-stream at index 4 -> all outputs cleared immediately; after release, no residual samples are emitted.
- With FFT_STREAM_MAG_EN: sample (re=-300, im=400) -> sample_mag=550. Sample (re=0x8000, im=0) -> sample_mag=32768.

Source files
------------

// File: rtl/fft_frame_streamer.sv
// fft_frame_streamer: captures packed N-point complex FFT frames into a
// two-bank ping-pong buffer and re-serializes them as a one-sample-per-beat
// valid/ready stream. Frames offered while both banks are full are dropped
// and counted.
// Optional build macro FFT_STREAM_MAG_EN adds a sample_mag output carrying
// an alpha-max-beta-min magnitude estimate of each streamed sample.
module fft_frame_streamer #(
    parameter int unsigned DATA_WIDTH      = 16,
    parameter int unsigned FFT_POINTS      = 8,
    parameter int unsigned LOG2_FFT_POINTS = $clog2(FFT_POINTS),
    parameter int unsigned DROP_CNT_WIDTH  = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [DATA_WIDTH*FFT_POINTS-1:0] frame_real_in,
    input  logic [DATA_WIDTH*FFT_POINTS-1:0] frame_imag_in,
    input  logic                           frame_valid_in,
    output logic                           frame_ready,
    output logic [DATA_WIDTH-1:0]          sample_real,
    output logic [DATA_WIDTH-1:0]          sample_imag,
    output logic [LOG2_FFT_POINTS-1:0]     sample_index,
    output logic                           sample_last,
    output logic                           sample_valid,
    input  logic                           sample_ready,
`ifdef FFT_STREAM_MAG_EN
    output logic [DATA_WIDTH:0]            sample_mag,
`endif
    output logic                           busy,
    output logic [DROP_CNT_WIDTH-1:0]      drop_count
);

    localparam int unsigned FW = DATA_WIDTH * FFT_POINTS;
    localparam int unsigned MW = DATA_WIDTH + 1;
    localparam logic [LOG2_FFT_POINTS-1:0] LAST_IDX = LOG2_FFT_POINTS'(FFT_POINTS - 1);

    typedef enum logic {
        ST_IDLE,
        ST_STREAM
    } state_e;

    // Storage and state
    logic [FW-1:0]               bank_re_q [2];
    logic [FW-1:0]               bank_im_q [2];
    logic                        fv_q;
    logic [1:0]                  cnt_q, cnt_d;
    logic                        wr_bank_q, wr_bank_d;
    logic                        rd_bank_q, rd_bank_d;
    state_e                      state_q, state_d;
    logic [DATA_WIDTH-1:0]       real_q, real_d;
    logic [DATA_WIDTH-1:0]       imag_q, imag_d;
    logic [LOG2_FFT_POINTS-1:0]  idx_q, idx_d;
    logic                        last_q, last_d;
    logic                        valid_q, valid_d;
    logic                        frame_ready_q, frame_ready_d;
    logic                        busy_q, busy_d;
    logic [DROP_CNT_WIDTH-1:0]   drop_q, drop_d;

    // Decode helpers
    logic                        capture_c;
    logic                        cap_ok_c;
    logic                        accept_c;
    logic                        last_acc_c;
    logic                        load_first_c;
    logic                        load_c;
    logic [LOG2_FFT_POINTS-1:0]  load_idx_c;
    logic [31:0]                 shift_c;
    logic [FW-1:0]               src_re_c;
    logic [FW-1:0]               src_im_c;
    logic [FW-1:0]               sh_re_c;
    logic [FW-1:0]               sh_im_c;

`ifdef FFT_STREAM_MAG_EN
    logic [MW-1:0]               mag_q, mag_d;
    logic [MW-1:0]               abs_re_c, abs_im_c;

    // Absolute value in a one-bit-wider path so the most negative value is exact
    function automatic logic [MW-1:0] abs_w(input logic [DATA_WIDTH-1:0] v);
        logic [MW-1:0] s;
        s = {v[DATA_WIDTH-1], v};
        return s[MW-1] ? (~s + MW'(1)) : s;
    endfunction
`endif

    // Next-state computation for capture, bank bookkeeping and the stream FSM
    always_comb begin
        capture_c  = frame_valid_in & ~fv_q;
        cap_ok_c   = capture_c & (cnt_q != 2'd2);
        accept_c   = valid_q & sample_ready;
        last_acc_c = accept_c & last_q;

        cnt_d     = cnt_q + 2'(cap_ok_c) - 2'(last_acc_c);
        wr_bank_d = wr_bank_q ^ cap_ok_c;
        rd_bank_d = rd_bank_q ^ last_acc_c;

        drop_d = drop_q;
        if (capture_c && !cap_ok_c && (drop_q != '1)) begin
            drop_d = drop_q + DROP_CNT_WIDTH'(1);
        end

        // Index 0 of a bank is presented from idle, or back-to-back when the
        // other bank was already full as the current one finishes.
        load_first_c = ((state_q == ST_IDLE) && (cnt_q != 2'd0)) ||
                       (last_acc_c && (cnt_q == 2'd2));
        load_c       = load_first_c | (accept_c & ~last_q);
        load_idx_c   = load_first_c ? '0 : (idx_q + LOG2_FFT_POINTS'(1));

        // rd_bank_d already points at the bank that is read after this edge
        src_re_c = bank_re_q[rd_bank_d];
        src_im_c = bank_im_q[rd_bank_d];
        shift_c  = 32'(load_idx_c) * DATA_WIDTH;
        sh_re_c  = src_re_c >> shift_c;
        sh_im_c  = src_im_c >> shift_c;

        state_d = state_q;
        real_d  = real_q;
        imag_d  = imag_q;
        idx_d   = idx_q;
        last_d  = last_q;
        if (load_c) begin
            state_d = ST_STREAM;
            real_d  = sh_re_c[DATA_WIDTH-1:0];
            imag_d  = sh_im_c[DATA_WIDTH-1:0];
            idx_d   = load_idx_c;
            last_d  = (load_idx_c == LAST_IDX);
        end else if (last_acc_c) begin
            state_d = ST_IDLE;
        end

`ifdef FFT_STREAM_MAG_EN
        abs_re_c = abs_w(sh_re_c[DATA_WIDTH-1:0]);
        abs_im_c = abs_w(sh_im_c[DATA_WIDTH-1:0]);
        mag_d    = mag_q;
        if (load_c) begin
            if (abs_re_c >= abs_im_c) begin
                mag_d = abs_re_c + (abs_im_c >> 1);
            end else begin
                mag_d = abs_im_c + (abs_re_c >> 1);
            end
        end
`endif

        valid_d       = (state_d == ST_STREAM);
        frame_ready_d = (cnt_d != 2'd2);
        busy_d        = (cnt_d != 2'd0) | valid_d;
    end

    // Control and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fv_q          <= 1'b0;
            cnt_q         <= 2'd0;
            wr_bank_q     <= 1'b0;
            rd_bank_q     <= 1'b0;
            state_q       <= ST_IDLE;
            real_q        <= '0;
            imag_q        <= '0;
            idx_q         <= '0;
            last_q        <= 1'b0;
            valid_q       <= 1'b0;
            frame_ready_q <= 1'b1;
            busy_q        <= 1'b0;
            drop_q        <= '0;
        end else begin
            fv_q          <= frame_valid_in;
            cnt_q         <= cnt_d;
            wr_bank_q     <= wr_bank_d;
            rd_bank_q     <= rd_bank_d;
            state_q       <= state_d;
            real_q        <= real_d;
            imag_q        <= imag_d;
            idx_q         <= idx_d;
            last_q        <= last_d;
            valid_q       <= valid_d;
            frame_ready_q <= frame_ready_d;
            busy_q        <= busy_d;
            drop_q        <= drop_d;
        end
    end

    // Frame storage; contents are qualified by cnt_q so no reset is needed
    always_ff @(posedge clk) begin
        if (cap_ok_c) begin
            bank_re_q[wr_bank_q] <= frame_real_in;
            bank_im_q[wr_bank_q] <= frame_imag_in;
        end
    end

`ifdef FFT_STREAM_MAG_EN
    // Magnitude estimate registered alongside the sample payload
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag_q <= '0;
        end else begin
            mag_q <= mag_d;
        end
    end

    assign sample_mag = mag_q;
`endif

    assign frame_ready  = frame_ready_q;
    assign sample_real  = real_q;
    assign sample_imag  = imag_q;
    assign sample_index = idx_q;
    assign sample_last  = last_q;
    assign sample_valid = valid_q;
    assign busy         = busy_q;
    assign drop_count   = drop_q;

endmodule

// File: tb/tb_fft_frame_streamer.sv
// Directed self-checking bench for fft_frame_streamer (DATA_WIDTH=16,
// FFT_POINTS=8). Define FFT_STREAM_MAG_EN to also exercise sample_mag.
module tb_fft_frame_streamer;

    localparam int DW  = 16;
    localparam int N   = 8;
    localparam int LG  = 3;
    localparam int DCW = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [DW*N-1:0] frame_real_in;
    logic [DW*N-1:0] frame_imag_in;
    logic            frame_valid_in;
    logic            frame_ready;
    logic [DW-1:0]   sample_real;
    logic [DW-1:0]   sample_imag;
    logic [LG-1:0]   sample_index;
    logic            sample_last;
    logic            sample_valid;
    logic            sample_ready;
    logic            busy;
    logic [DCW-1:0]  drop_count;
`ifdef FFT_STREAM_MAG_EN
    logic [DW:0]     sample_mag;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fft_frame_streamer #(
        .DATA_WIDTH     (DW),
        .FFT_POINTS     (N),
        .LOG2_FFT_POINTS(LG),
        .DROP_CNT_WIDTH (DCW)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_real_in (frame_real_in),
        .frame_imag_in (frame_imag_in),
        .frame_valid_in(frame_valid_in),
        .frame_ready   (frame_ready),
        .sample_real   (sample_real),
        .sample_imag   (sample_imag),
        .sample_index  (sample_index),
        .sample_last   (sample_last),
        .sample_valid  (sample_valid),
        .sample_ready  (sample_ready),
`ifdef FFT_STREAM_MAG_EN
        .sample_mag    (sample_mag),
`endif
        .busy          (busy),
        .drop_count    (drop_count)
    );

    // Compare one observed value against its expectation
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Frame test patterns: frame 0 is the hand pattern, others are distinct tags
    function automatic logic [DW-1:0] exp_re(input int f, input int i);
        case (f)
            0:       return 16'(i * 256);
            1:       return 16'(16'h1000 + i);
            2:       return 16'(16'h2000 + i);
            3:       return (i == 0) ? 16'hFED4 : ((i == 1) ? 16'h8000 : 16'h0000);
            default: return 16'(16'h7000 + i);
        endcase
    endfunction

    function automatic logic [DW-1:0] exp_im(input int f, input int i);
        case (f)
            0:       return 16'(-i);
            1:       return 16'(16'h0A00 + i);
            2:       return 16'(16'h0B00 + i);
            3:       return (i == 0) ? 16'd400 : 16'h0000;
            default: return 16'(16'h0C00 + i);
        endcase
    endfunction

    // Reference magnitude estimate using plain integer arithmetic
    function automatic int mag_model(input logic [DW-1:0] r, input logic [DW-1:0] m);
        int a, b;
        a = int'($signed(r));
        b = int'($signed(m));
        if (a < 0) a = -a;
        if (b < 0) b = -b;
        return (a >= b) ? (a + b / 2) : (b + a / 2);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int f);
        for (int i = 0; i < N; i++) begin
            frame_real_in[i*DW +: DW] = exp_re(f, i);
            frame_imag_in[i*DW +: DW] = exp_im(f, i);
        end
    endtask

    // Offer one frame with a single rising edge of frame_valid_in
    task automatic offer(input int f);
        load(f);
        frame_valid_in = 1'b1;
        tick();
        frame_valid_in = 1'b0;
        tick();
    endtask

    // Drain nfr frames starting at pattern f0; mode 1 applies ready 1,0,0 repeating
    task automatic collect(input int f0, input int mode, input int nfr);
        int k, cyc, f, i, total;
        bit started, stalled;
        logic [DW-1:0] hr, hi;
        logic [LG-1:0] hx;
        k = 0; cyc = 0; started = 0; stalled = 0;
        hr = '0; hi = '0; hx = '0;
        total = nfr * N;
        while (k < total && cyc < 200) begin
            sample_ready = (mode == 1) ? ((cyc % 3) == 0) : 1'b1;
            if (stalled) begin
                chk("hold_re", 64'(sample_real), 64'(hr));
                chk("hold_im", 64'(sample_imag), 64'(hi));
                chk("hold_idx", 64'(sample_index), 64'(hx));
            end
            if (started) chk("no_bubble", 64'(sample_valid), 64'd1);
            if (sample_valid) begin
                started = 1;
                f = f0 + k / N;
                i = k % N;
                if (sample_ready) begin
                    chk("re", 64'(sample_real), 64'(exp_re(f, i)));
                    chk("im", 64'(sample_imag), 64'(exp_im(f, i)));
                    chk("idx", 64'(sample_index), 64'(i));
                    chk("last", 64'(sample_last), 64'(i == N - 1));
                    if (f == 0 && i == 3) begin
                        chk("s3_re", 64'(sample_real), 64'h0300);
                        chk("s3_im", 64'(sample_imag), 64'hFFFD);
                    end
`ifdef FFT_STREAM_MAG_EN
                    chk("mag", 64'(sample_mag), 64'(mag_model(exp_re(f, i), exp_im(f, i))));
`endif
                    k++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    hr = sample_real;
                    hi = sample_imag;
                    hx = sample_index;
                end
            end
            tick();
            cyc++;
        end
        chk("beats", 64'(k), 64'(total));
    endtask

    initial begin
        int beats;
        int cyc;
        rst_n          = 1'b0;
        frame_real_in  = '0;
        frame_imag_in  = '0;
        frame_valid_in = 1'b0;
        sample_ready   = 1'b0;
        #12;
        chk("rst_valid", 64'(sample_valid), 64'd0);
        chk("rst_fready", 64'(frame_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_drop", 64'(drop_count), 64'd0);
        chk("rst_re", 64'(sample_real), 64'd0);
        chk("rst_last", 64'(sample_last), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single frame with ready held high; check capture-to-valid latency
        load(0);
        sample_ready   = 1'b1;
        frame_valid_in = 1'b1;
        tick();
        frame_valid_in = 1'b0;
        chk("lat_valid0", 64'(sample_valid), 64'd0);
        chk("lat_busy", 64'(busy), 64'd1);
        chk("lat_fready", 64'(frame_ready), 64'd1);
        tick();
        chk("lat_valid1", 64'(sample_valid), 64'd1);
        chk("lat_idx0", 64'(sample_index), 64'd0);
        collect(0, 0, 1);
        chk("t1_busy", 64'(busy), 64'd0);
        chk("t1_fready", 64'(frame_ready), 64'd1);
        chk("t1_valid", 64'(sample_valid), 64'd0);

        // Backpressure with ready 1,0,0,...
        offer(0);
        collect(0, 1, 1);
        chk("t2_busy", 64'(busy), 64'd0);

        // Level held high for 40 cycles captures exactly one frame
        load(1);
        sample_ready   = 1'b1;
        frame_valid_in = 1'b1;
        beats = 0;
        repeat (40) begin
            if (sample_valid && sample_ready) beats++;
            tick();
        end
        frame_valid_in = 1'b0;
        tick();
        chk("t3_beats", 64'(beats), 64'd8);
        chk("t3_drop", 64'(drop_count), 64'd0);
        chk("t3_busy", 64'(busy), 64'd0);

        // Three edges while stalled: two buffered, third dropped
        sample_ready = 1'b0;
        offer(1);
        offer(2);
        chk("t4_fready2", 64'(frame_ready), 64'd0);
        offer(4);
        chk("t4_drop", 64'(drop_count), 64'd1);
        chk("t4_fready", 64'(frame_ready), 64'd0);
        chk("t4_busy", 64'(busy), 64'd1);
        chk("t4_valid", 64'(sample_valid), 64'd1);
        chk("t4_re0", 64'(sample_real), 64'h1000);
        collect(1, 0, 2);
        chk("t4_busy_end", 64'(busy), 64'd0);
        chk("t4_fready_end", 64'(frame_ready), 64'd1);
        chk("t4_drop_end", 64'(drop_count), 64'd1);

        // Reset asserted mid-stream at index 4
        load(0);
        sample_ready   = 1'b1;
        frame_valid_in = 1'b1;
        tick();
        frame_valid_in = 1'b0;
        cyc = 0;
        while (!(sample_valid && sample_index == 3'd4) && cyc < 30) begin
            tick();
            cyc++;
        end
        chk("t5_reach_idx4", 64'(sample_index), 64'd4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_valid", 64'(sample_valid), 64'd0);
        chk("t5_re", 64'(sample_real), 64'd0);
        chk("t5_idx", 64'(sample_index), 64'd0);
        chk("t5_fready", 64'(frame_ready), 64'd1);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_drop", 64'(drop_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        beats = 0;
        repeat (20) begin
            tick();
            if (sample_valid) beats++;
        end
        chk("t5_residual", 64'(beats), 64'd0);

`ifdef FFT_STREAM_MAG_EN
        // Magnitude estimate: (-300,400) and the most negative real value
        sample_ready = 1'b0;
        offer(3);
        chk("m_re0", 64'(sample_real), 64'hFED4);
        chk("m_mag0", 64'(sample_mag), 64'd550);
        sample_ready = 1'b1;
        tick();
        chk("m_idx1", 64'(sample_index), 64'd1);
        chk("m_mag1", 64'(sample_mag), 64'd32768);
        repeat (10) tick();
        chk("m_busy", 64'(busy), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
